// File: rtl/dcm_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcm_reset_pkg
// Brief    : Shared state encoding and widths for the DCM reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dcm_reset_pkg;

  typedef enum logic [2:0] {
    ST_DELAY  = 3'd0,
    ST_PULSE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } dcm_state_e;

  localparam int c_RETRY_W    = 4;
  localparam int c_SYNC_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/dcm_reset_channel.sv
`default_nettype none
// ============================================================================
// Module   : dcm_reset_channel
// Brief    : One DCM reset/lock channel: LOCKED synchroniser, FSM and counters.
// Revision : 1.0 - initial release
// ============================================================================
module dcm_reset_channel
  import dcm_reset_pkg::*;
#(
  parameter int STARTUP_DELAY = 11,
  parameter int RESET_WIDTH   = 4,
  parameter int LOCK_FILTER   = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOCKED,
  input  logic                 FORCE_RESET,
  output logic                 DCM_RESET,
  output logic                 CH_LOCKED,
  output logic                 LOCK_LOST,
  output logic                 FAULT,
  output logic [c_RETRY_W-1:0] RETRY_CNT
);

  localparam logic [CNT_WIDTH-1:0] c_DELAY_END   = CNT_WIDTH'(STARTUP_DELAY);
  localparam logic [CNT_WIDTH-1:0] c_PULSE_END   = CNT_WIDTH'(RESET_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_FILTER_END  = CNT_WIDTH'(LOCK_FILTER);
  localparam logic [CNT_WIDTH-1:0] c_TIMEOUT_END = CNT_WIDTH'(LOCK_TIMEOUT);
  localparam logic [c_RETRY_W-1:0] c_RETRY_MAX   = c_RETRY_W'(MAX_RETRIES);
  localparam logic [c_RETRY_W-1:0] c_RETRY_SAT   = '1;

  // Initial values match the reset values so the block sequences with RST tied low.
  dcm_state_e              r_state     = ST_DELAY;
  logic [c_SYNC_DEPTH-1:0] r_sync      = '0;
  logic [CNT_WIDTH-1:0]    r_cnt       = '0;
  logic [CNT_WIDTH-1:0]    r_filt      = '0;
  logic [c_RETRY_W-1:0]    r_retry     = '0;
  logic [c_RETRY_W-1:0]    r_retry_cnt = '0;
  logic                    r_dcm_reset = 1'b0;
  logic                    r_ch_locked = 1'b0;
  logic                    r_lock_lost = 1'b0;
  logic                    r_fault     = 1'b0;

  dcm_state_e           w_state_next;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [CNT_WIDTH-1:0] w_filt_inc;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH-1:0] w_filt_next;
  logic [c_RETRY_W-1:0] w_retry_next;
  logic [c_RETRY_W-1:0] w_retry_cnt_next;
  logic                 w_lock_lost;
  logic                 w_locked_s;
  logic                 w_dcm_reset;
  logic                 w_ch_locked;
  logic                 w_fault;

  assign w_locked_s = r_sync[c_SYNC_DEPTH-1];
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_filt_inc = r_filt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[c_SYNC_DEPTH-2:0], LOCKED};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_DELAY;
      r_cnt       <= '0;
      r_filt      <= '0;
      r_retry     <= '0;
      r_retry_cnt <= '0;
      r_dcm_reset <= 1'b0;
      r_ch_locked <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_filt      <= w_filt_next;
      r_retry     <= w_retry_next;
      r_retry_cnt <= w_retry_cnt_next;
      r_dcm_reset <= w_dcm_reset;
      r_ch_locked <= w_ch_locked;
      r_lock_lost <= w_lock_lost;
      r_fault     <= w_fault;
    end
  end

  // FORCE_RESET overrides every other event; the shared counter restarts on each state change.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = w_cnt_inc;
    w_filt_next      = '0;
    w_retry_next     = r_retry;
    w_retry_cnt_next = r_retry_cnt;
    w_lock_lost      = 1'b0;
    if (FORCE_RESET) begin
      w_state_next     = ST_PULSE;
      w_cnt_next       = '0;
      w_retry_next     = '0;
      w_retry_cnt_next = '0;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_cnt == c_DELAY_END) begin
            w_state_next = ST_PULSE;
            w_cnt_next   = '0;
          end
        end
        ST_PULSE: begin
          if (r_cnt == c_PULSE_END) begin
            w_state_next = ST_WAIT;
            w_cnt_next   = '0;
          end
        end
        ST_WAIT: begin
          w_filt_next = w_locked_s ? w_filt_inc : '0;
          if (w_locked_s && (w_filt_inc == c_FILTER_END)) begin
            w_state_next = ST_LOCKED;
            w_cnt_next   = '0;
            w_filt_next  = '0;
            w_retry_next = '0;
          end else if (w_cnt_inc == c_TIMEOUT_END) begin
            w_cnt_next  = '0;
            w_filt_next = '0;
            if (r_retry_cnt != c_RETRY_SAT) w_retry_cnt_next = r_retry_cnt + 1'b1;
            if (r_retry != c_RETRY_SAT) w_retry_next = r_retry + 1'b1;
            if ((MAX_RETRIES != 0) && (w_retry_next == c_RETRY_MAX)) begin
              w_state_next = ST_FAULT;
            end else begin
              w_state_next = ST_PULSE;
            end
          end
        end
        ST_LOCKED: begin
          w_cnt_next = '0;
          if (!w_locked_s) begin
            w_state_next = ST_PULSE;
            w_lock_lost  = 1'b1;
            w_retry_next = '0;
          end
        end
        ST_FAULT: begin
          w_cnt_next = '0;
        end
        default: begin
          w_state_next = ST_DELAY;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, keeping DCM_RESET glitch-free.
  always_comb begin
    w_dcm_reset = (w_state_next == ST_PULSE);
    w_ch_locked = (w_state_next == ST_LOCKED);
    w_fault     = (w_state_next == ST_FAULT);
  end

  assign DCM_RESET = r_dcm_reset;
  assign CH_LOCKED = r_ch_locked;
  assign LOCK_LOST = r_lock_lost;
  assign FAULT     = r_fault;
  assign RETRY_CNT = r_retry_cnt;

endmodule
`default_nettype wire

// File: rtl/dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dcm_reset_sequencer
// Brief    : Power-on/recovery reset sequencer for NUM_DCM clock managers.
// Revision : 1.0 - initial release
// ============================================================================
module dcm_reset_sequencer
  import dcm_reset_pkg::*;
#(
  parameter int NUM_DCM       = 2,
  parameter int STARTUP_DELAY = 11,
  parameter int RESET_WIDTH   = 4,
  parameter int LOCK_FILTER   = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_DCM-1:0]             LOCKED,
  input  logic [NUM_DCM-1:0]             FORCE_RESET,
  output logic [NUM_DCM-1:0]             DCM_RESET,
  output logic [NUM_DCM-1:0]             CH_LOCKED,
  output logic                           ALL_LOCKED,
  output logic [NUM_DCM-1:0]             LOCK_LOST,
  output logic [NUM_DCM-1:0]             FAULT,
  output logic [NUM_DCM*c_RETRY_W-1:0]   RETRY_CNT
);

  logic r_all_locked = 1'b0;

  generate
    for (genvar gi = 0; gi < NUM_DCM; gi++) begin : g_ch
      dcm_reset_channel #(
        .STARTUP_DELAY (STARTUP_DELAY),
        .RESET_WIDTH   (RESET_WIDTH),
        .LOCK_FILTER   (LOCK_FILTER),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_WIDTH     (CNT_WIDTH)
      ) u_channel (
        .CLK         (CLK),
        .RST         (RST),
        .LOCKED      (LOCKED[gi]),
        .FORCE_RESET (FORCE_RESET[gi]),
        .DCM_RESET   (DCM_RESET[gi]),
        .CH_LOCKED   (CH_LOCKED[gi]),
        .LOCK_LOST   (LOCK_LOST[gi]),
        .FAULT       (FAULT[gi]),
        .RETRY_CNT   (RETRY_CNT[gi*c_RETRY_W +: c_RETRY_W])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_all_locked <= 1'b0;
    end else begin
      r_all_locked <= &CH_LOCKED;
    end
  end

  assign ALL_LOCKED = r_all_locked;

endmodule
`default_nettype wire

// File: tb/tb_dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcm_reset_sequencer
// Brief    : Directed + random bench against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dcm_reset_sequencer;

  localparam int N  = 2;
  localparam int SD = 11;
  localparam int RW = 4;
  localparam int LF = 8;
  localparam int LT = 100;
  localparam int MR = 3;

  localparam int M_DELAY  = 0;
  localparam int M_PULSE  = 1;
  localparam int M_WAIT   = 2;
  localparam int M_LOCKED = 3;
  localparam int M_FAULT  = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   LOCKED = '0;
  logic [N-1:0]   FORCE_RESET = '0;
  logic [N-1:0]   DCM_RESET;
  logic [N-1:0]   CH_LOCKED;
  logic           ALL_LOCKED;
  logic [N-1:0]   LOCK_LOST;
  logic [N-1:0]   FAULT;
  logic [N*4-1:0] RETRY_CNT;

  dcm_reset_sequencer #(
    .NUM_DCM       (N),
    .STARTUP_DELAY (SD),
    .RESET_WIDTH   (RW),
    .LOCK_FILTER   (LF),
    .LOCK_TIMEOUT  (LT),
    .MAX_RETRIES   (MR),
    .CNT_WIDTH     (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .LOCKED      (LOCKED),
    .FORCE_RESET (FORCE_RESET),
    .DCM_RESET   (DCM_RESET),
    .CH_LOCKED   (CH_LOCKED),
    .ALL_LOCKED  (ALL_LOCKED),
    .LOCK_LOST   (LOCK_LOST),
    .FAULT       (FAULT),
    .RETRY_CNT   (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: each channel is a mode plus the edge number at which it was entered.
  int m_mode[N];
  int m_t[N];
  int m_last_low[N];
  int m_retry[N];
  int m_rc[N];
  bit m_s1[N];
  bit m_s2[N];
  bit m_lost[N];
  bit m_all;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    bit all_next;
    bit sync;
    int since;
    all_next = 1'b1;
    for (int i = 0; i < N; i++) all_next &= (m_mode[i] == M_LOCKED);
    for (int i = 0; i < N; i++) begin
      sync = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = LOCKED[i];
      m_lost[i] = 1'b0;
      if (RST) begin
        m_s1[i] = 1'b0;
        m_s2[i] = 1'b0;
        m_mode[i] = M_DELAY;
        m_t[i] = edge_n;
        m_last_low[i] = edge_n;
        m_retry[i] = 0;
        m_rc[i] = 0;
      end else begin
        if (!sync) m_last_low[i] = edge_n;
        if (FORCE_RESET[i]) begin
          m_mode[i] = M_PULSE;
          m_t[i] = edge_n;
          m_retry[i] = 0;
          m_rc[i] = 0;
        end else begin
          case (m_mode[i])
            M_DELAY: if (edge_n - m_t[i] == SD + 1) begin
              m_mode[i] = M_PULSE;
              m_t[i] = edge_n;
            end
            M_PULSE: if (edge_n - m_t[i] == RW) begin
              m_mode[i] = M_WAIT;
              m_t[i] = edge_n;
            end
            M_WAIT: begin
              since = (m_last_low[i] > m_t[i]) ? m_last_low[i] : m_t[i];
              if (edge_n - since >= LF) begin
                m_mode[i] = M_LOCKED;
                m_retry[i] = 0;
                m_t[i] = edge_n;
              end else if (edge_n - m_t[i] >= LT) begin
                m_rc[i] = (m_rc[i] < 15) ? m_rc[i] + 1 : 15;
                m_retry[i] = m_retry[i] + 1;
                m_mode[i] = (MR != 0 && m_retry[i] == MR) ? M_FAULT : M_PULSE;
                m_t[i] = edge_n;
              end
            end
            M_LOCKED: if (!sync) begin
              m_mode[i] = M_PULSE;
              m_lost[i] = 1'b1;
              m_retry[i] = 0;
              m_t[i] = edge_n;
            end
            default: ;
          endcase
        end
      end
    end
    m_all = RST ? 1'b0 : all_next;
  endtask

  task automatic compare_model();
    logic [N-1:0]   e_dcm, e_lck, e_lost, e_flt;
    logic [N*4-1:0] e_rc;
    for (int i = 0; i < N; i++) begin
      e_dcm[i]       = (m_mode[i] == M_PULSE);
      e_lck[i]       = (m_mode[i] == M_LOCKED);
      e_flt[i]       = (m_mode[i] == M_FAULT);
      e_lost[i]      = m_lost[i];
      e_rc[i*4 +: 4] = 4'(m_rc[i]);
    end
    check("DCM_RESET",  32'(DCM_RESET),  32'(e_dcm));
    check("CH_LOCKED",  32'(CH_LOCKED),  32'(e_lck));
    check("ALL_LOCKED", 32'(ALL_LOCKED), 32'(m_all));
    check("LOCK_LOST",  32'(LOCK_LOST),  32'(e_lost));
    check("FAULT",      32'(FAULT),      32'(e_flt));
    check("RETRY_CNT",  32'(RETRY_CNT),  32'(e_rc));
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] lk, input logic [N-1:0] frc);
    RST = rst;
    LOCKED = lk;
    FORCE_RESET = frc;
    @(posedge CLK);
    model_edge();
    edge_n++;
    @(negedge CLK);
    compare_model();
  endtask

  initial begin
    logic [N-1:0] rlk;
    logic [N-1:0] rfrc;
    logic         rrst;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = M_DELAY; m_t[i] = 0; m_last_low[i] = 0;
      m_retry[i] = 0; m_rc[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_lost[i] = 0;
    end
    m_all = 1'b0;

    // Reset state
    for (int k = 0; k < 3; k++) cycle(1'b1, 2'b11, 2'b00);
    check("rst_dcm_reset", 32'(DCM_RESET), 32'h0);
    check("rst_retry_cnt", 32'(RETRY_CNT), 32'h0);

    // Power-up: pulse on relative edges 11..14, lock at 23, ALL_LOCKED at 24
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 2'b11, 2'b00);
      if (k == 10) check("pre_pulse",   32'(DCM_RESET),  32'h0);
      if (k == 11) check("pulse_start", 32'(DCM_RESET),  32'h3);
      if (k == 14) check("pulse_last",  32'(DCM_RESET),  32'h3);
      if (k == 15) check("pulse_end",   32'(DCM_RESET),  32'h0);
      if (k == 22) check("prelock",     32'(CH_LOCKED),  32'h0);
      if (k == 23) check("lock_time",   32'(CH_LOCKED),  32'h3);
      if (k == 23) check("all_pre",     32'(ALL_LOCKED), 32'h0);
      if (k == 24) check("all_locked",  32'(ALL_LOCKED), 32'h1);
    end

    // One-cycle LOCKED[1] drop: loss seen two edges later, then relock
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, (k == 0) ? 2'b01 : 2'b11, 2'b00);
      if (k == 2) check("lost_pulse", 32'(LOCK_LOST), 32'h2);
      if (k == 3) check("lost_once",  32'(LOCK_LOST), 32'h0);
      if (k == 3) check("all_drop",   32'(ALL_LOCKED), 32'h0);
      if (k == 3) check("repulse",    32'(DCM_RESET), 32'h2);
      if (k == 39) check("relock",    32'(CH_LOCKED), 32'h3);
    end

    // Glitchy LOCKED[0]: 5 high / 1 low never satisfies the filter
    for (int k = 0; k < 60; k++) cycle(1'b0, {1'b1, (k % 6 != 5)}, 2'b00);
    check("glitch_nolock", 32'(CH_LOCKED), 32'h2);
    for (int k = 0; k < 20; k++) cycle(1'b0, 2'b11, 2'b00);
    check("glitch_relock", 32'(CH_LOCKED), 32'h3);

    // LOCKED[0] dead: three attempts then FAULT
    for (int k = 0; k < 340; k++) cycle(1'b0, 2'b10, 2'b00);
    check("fault_set",   32'(FAULT), 32'h1);
    check("fault_retry", 32'(RETRY_CNT[3:0]), 32'h3);
    check("fault_nodcm", 32'(DCM_RESET), 32'h0);
    check("ch1_ok",      32'(CH_LOCKED), 32'h2);

    // FORCE_RESET on both channels on the edge channel 1 sees its LOCKED drop
    cycle(1'b0, 2'b01, 2'b00);
    cycle(1'b0, 2'b11, 2'b00);
    cycle(1'b0, 2'b11, 2'b11);
    check("force_nolost", 32'(LOCK_LOST), 32'h0);
    check("force_fault",  32'(FAULT), 32'h0);
    check("force_retry",  32'(RETRY_CNT), 32'h0);
    check("force_pulse",  32'(DCM_RESET), 32'h3);
    for (int k = 0; k < 40; k++) cycle(1'b0, 2'b11, 2'b00);

    // Randomised LOCKED activity with occasional forces and resets
    rlk = 2'b11;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 19) == 0) rlk[i] = ~rlk[i];
      for (int i = 0; i < N; i++) rfrc[i] = ($urandom_range(0, 99) == 0);
      rrst = ($urandom_range(0, 399) == 0);
      cycle(rrst, rlk, rfrc);
    end

    // RST in the middle of a pulse truncates it; next pulse exactly SD edges after release
    cycle(1'b0, 2'b11, 2'b01);
    check("mid_pulse", 32'(DCM_RESET[0]), 32'h1);
    cycle(1'b1, 2'b11, 2'b00);
    check("rst_trunc", 32'(DCM_RESET), 32'h0);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 2'b11, 2'b00);
      if (k == 10) check("rerst_pre",   32'(DCM_RESET), 32'h0);
      if (k == 11) check("rerst_pulse", 32'(DCM_RESET), 32'h3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
